// File: rtl/vga_receiver.sv
// VGA sink: samples HSync/VSync/RGB once per clk, locks onto the sync timing and
// reports the row/col of every pixel two clocks after it was on the pins.
module vga_receiver #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       HSync,
    input  logic       VSync,
    input  logic       R_in,
    input  logic       G_in,
    input  logic       B_in,
    output logic [9:0] row,
    output logic [9:0] col,
    output logic       R_out,
    output logic       G_out,
    output logic       B_out,
    output logic       pixel_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       h_err,
    output logic       v_err
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_COL  = 10'(H_VIS + H_FP);
    localparam logic [9:0] VS_ROW  = 10'(V_VIS + V_FP);
    localparam logic [9:0] H_VIS_C = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C = 10'(V_VIS);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        HTRACK = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Sample stage; the *_d_reg copies hold the previous sample for edge detection.
    logic hs_s_reg, hs_d_reg, vs_s_reg, vs_d_reg;
    logic hs_edge, vs_edge;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hs_s_reg <= 1'b1;
            hs_d_reg <= 1'b1;
            vs_s_reg <= 1'b1;
            vs_d_reg <= 1'b1;
        end else begin
            hs_s_reg <= HSync;
            hs_d_reg <= hs_s_reg;
            vs_s_reg <= VSync;
            vs_d_reg <= vs_s_reg;
        end
    end

    assign hs_edge = !hs_s_reg && hs_d_reg;
    assign vs_edge = !vs_s_reg && vs_d_reg;

    // Tracking state: the row/col assigned to the previous sample.
    state_t     state_reg, state_next;
    logic [9:0] col_cnt_reg, col_cnt_next;
    logic [9:0] row_cnt_reg, row_cnt_next;
    logic [9:0] c_col, c_row;
    logic       h_err_next, v_err_next;
    logic       at_vs;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= SEARCH;
            col_cnt_reg <= '0;
            row_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            col_cnt_reg <= col_cnt_next;
            row_cnt_reg <= row_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        col_cnt_next = col_cnt_reg;
        row_cnt_next = row_cnt_reg;
        h_err_next   = 1'b0;
        v_err_next   = 1'b0;
        at_vs        = 1'b0;

        c_col = (col_cnt_reg == H_LAST) ? 10'd0 : col_cnt_reg + 10'd1;
        if (col_cnt_reg == H_LAST) begin
            c_row = (row_cnt_reg == V_LAST) ? 10'd0 : row_cnt_reg + 10'd1;
        end else begin
            c_row = row_cnt_reg;
        end

        case (state_reg)
            SEARCH: begin
                col_cnt_next = '0;
                row_cnt_next = '0;
                if (hs_edge) begin
                    col_cnt_next = HS_COL;
                    state_next   = HTRACK;
                end
            end
            default: begin
                col_cnt_next = c_col;
                row_cnt_next = c_row;
                // Horizontal check wins; a VSync edge on an h_err sample is dropped.
                if (hs_edge && (c_col != HS_COL)) begin
                    h_err_next   = 1'b1;
                    col_cnt_next = HS_COL;
                    state_next   = HTRACK;
                end else if (!hs_edge && (c_col == HS_COL)) begin
                    h_err_next   = 1'b1;
                    col_cnt_next = '0;
                    row_cnt_next = '0;
                    state_next   = SEARCH;
                end else if (state_reg == HTRACK) begin
                    if (vs_edge) begin
                        row_cnt_next = VS_ROW;
                        state_next   = LOCKED;
                    end
                end else begin
                    at_vs = (c_row == VS_ROW) && (c_col == 10'd0);
                    if (vs_edge && !at_vs) begin
                        v_err_next   = 1'b1;
                        row_cnt_next = VS_ROW;
                    end else if (!vs_edge && at_vs) begin
                        v_err_next = 1'b1;
                        state_next = HTRACK;
                    end
                end
            end
        endcase
    end

    // Output stage describes the sample just classified above.
    logic       locked_next, valid_next, frame_start_next;
    logic [9:0] row_next;

    assign locked_next      = (state_next == LOCKED);
    assign row_next         = locked_next ? row_cnt_next : 10'd0;
    assign valid_next       = locked_next && (row_cnt_next < V_VIS_C) && (col_cnt_next < H_VIS_C);
    assign frame_start_next = locked_next && (row_cnt_next == 10'd0) && (col_cnt_next == 10'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            row         <= '0;
            col         <= '0;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
        end else begin
            row         <= row_next;
            col         <= col_cnt_next;
            pixel_valid <= valid_next;
            frame_start <= frame_start_next;
            locked      <= locked_next;
            h_err       <= h_err_next;
            v_err       <= v_err_next;
        end
    end

    // Colour channels: sample register, then output register gated by pixel_valid.
    logic [2:0] rgb_in, rgb_out;
    assign rgb_in = {R_in, G_in, B_in};

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        logic s_reg, o_reg;
        always_ff @(posedge clk) begin
            if (!reset) begin
                s_reg <= 1'b0;
                o_reg <= 1'b0;
            end else begin
                s_reg <= rgb_in[gi];
                o_reg <= s_reg & valid_next;
            end
        end
        assign rgb_out[gi] = o_reg;
    end

    assign R_out = rgb_out[2];
    assign G_out = rgb_out[1];
    assign B_out = rgb_out[0];

endmodule

// File: tb/tb_vga_receiver.sv
// Scoreboard bench for vga_receiver on a reduced 25x15 raster: the driver queues the
// expected output for every pixel it drives, a monitor pops and compares 2 clk later.
module tb_vga_receiver;

    localparam int H_VIS = 16, H_FP = 2, H_SYNC = 4, H_BP = 3;
    localparam int V_VIS = 8,  V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;   // 25
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;   // 15
    localparam int HS_COL  = H_VIS + H_FP;                   // 18
    localparam int VS_ROW  = V_VIS + V_FP;                   // 10

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       HSync = 1'b1, VSync = 1'b1;
    logic       R_in = 1'b1, G_in = 1'b1, B_in = 1'b1;
    logic [9:0] row, col;
    logic       R_out, G_out, B_out, pixel_valid, frame_start, locked, h_err, v_err;

    vga_receiver #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk), .reset(reset), .HSync(HSync), .VSync(VSync),
        .R_in(R_in), .G_in(G_in), .B_in(B_in),
        .row(row), .col(col), .R_out(R_out), .G_out(G_out), .B_out(B_out),
        .pixel_valid(pixel_valid), .frame_start(frame_start), .locked(locked),
        .h_err(h_err), .v_err(v_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         cyc;
        logic [9:0] row;
        logic [9:0] col;
        logic [2:0] rgb;
        logic       pv, fs, lk, he, ve, chk;
    } exp_t;

    typedef enum {P_SEARCH, P_HTRACK, P_LOCKED} phase_t;

    exp_t   q[$];
    int     cyc = 0;
    int     checks = 0;
    int     passes = 0;
    int     srow, scol;
    int     sup_row = -1;
    phase_t phase = P_SEARCH;
    logic   frame_clean = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each queued pixel is due on the outputs two clocks after it was driven.
    initial begin
        exp_t        e;
        logic [27:0] act, expv;
        int          pv_cnt;
        pv_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0 && q[0].cyc == cyc - 2) begin
                e    = q.pop_front();
                act  = {row, col, R_out, G_out, B_out, pixel_valid, frame_start, locked, h_err, v_err};
                expv = {e.row, e.col, e.rgb, e.pv, e.fs, e.lk, e.he, e.ve};
                if (e.chk) begin
                    checks++;
                    if (pv_cnt == H_VIS * V_VIS) passes++;
                    else $display("FAIL pv_count frame: got %0d want %0d", pv_cnt, H_VIS * V_VIS);
                end
                if (frame_start) pv_cnt = 0;
                if (pixel_valid) pv_cnt++;
                checks++;
                if (act === expv) passes++;
                else $display("FAIL pixel cyc=%0d: got row=%0d col=%0d rgb=%b pv=%b fs=%b lk=%b he=%b ve=%b  want row=%0d col=%0d rgb=%b pv=%b fs=%b lk=%b he=%b ve=%b",
                              e.cyc, row, col, {R_out, G_out, B_out}, pixel_valid, frame_start, locked, h_err, v_err,
                              e.row, e.col, e.rgb, e.pv, e.fs, e.lk, e.he, e.ve);
                $display("px cyc=%0d row=%0d col=%0d pv=%b lk=%b he=%b ve=%b", e.cyc, row, col, pixel_valid, locked, h_err, v_err);
            end
        end
    end

    task automatic idle_px();
        exp_t e;
        @(posedge clk);
        #1;
        {HSync, VSync, R_in, G_in, B_in} = 5'b11111;
        e     = '0;
        e.cyc = cyc;
        q.push_back(e);
    endtask

    // Drive the source pixel (srow,scol); jump_h/jump_v mark an injected phase jump.
    task automatic drive_px(input logic jump_h, input logic jump_v, input logic rst);
        exp_t e;
        logic herr, verr, hs, vs, lk, pv;
        herr = 1'b0;
        verr = 1'b0;
        hs = !(scol >= HS_COL && scol < HS_COL + H_SYNC && srow != sup_row);
        vs = !(srow >= VS_ROW && srow < VS_ROW + V_SYNC);
        @(posedge clk);
        #1;
        reset = !rst;
        HSync = hs;
        VSync = vs;
        R_in  = scol[2];
        G_in  = scol[1];
        B_in  = scol[0];

        if (rst) phase = P_SEARCH;
        else if (jump_h) begin
            herr  = 1'b1;
            phase = P_HTRACK;
        end else if (phase != P_SEARCH && scol == HS_COL && srow == sup_row) begin
            herr  = 1'b1;
            phase = P_SEARCH;
        end else if (phase == P_SEARCH && scol == HS_COL && srow != sup_row) phase = P_HTRACK;
        else if (jump_v) verr = 1'b1;
        else if (phase == P_HTRACK && srow == VS_ROW && scol == 0) phase = P_LOCKED;

        lk     = (phase == P_LOCKED);
        pv     = lk && srow < V_VIS && scol < H_VIS;
        e      = '0;
        e.cyc  = cyc;
        e.he   = herr;
        e.ve   = verr;
        e.lk   = lk;
        e.col  = (phase == P_SEARCH) ? 10'd0 : 10'(scol);
        e.row  = lk ? 10'(srow) : 10'd0;
        e.pv   = pv;
        e.rgb  = pv ? scol[2:0] : 3'b000;
        e.fs   = lk && srow == 0 && scol == 0;
        e.chk  = e.fs && frame_clean;
        if (srow == 0 && scol == 0) frame_clean = lk;
        if (herr || verr || !lk) frame_clean = 1'b0;
        // A reset also wipes the pixel still in the sample stage.
        if (rst && q.size() > 0) begin
            q[q.size() - 1].row = '0;
            q[q.size() - 1].col = '0;
            q[q.size() - 1].rgb = '0;
            {q[q.size() - 1].pv, q[q.size() - 1].fs, q[q.size() - 1].lk} = 3'b000;
            {q[q.size() - 1].he, q[q.size() - 1].ve, q[q.size() - 1].chk} = 3'b000;
        end
        q.push_back(e);

        scol++;
        if (scol == H_TOTAL) begin
            scol = 0;
            srow++;
            if (srow == V_TOTAL) srow = 0;
        end
    endtask

    task automatic run_to(input int r, input int c);
        int n;
        n = 0;
        do begin
            drive_px(1'b0, 1'b0, 1'b0);
            n++;
        end while (!(srow == r && scol == c) && n < 4000);
        if (n >= 4000) begin
            checks++;
            $display("FAIL run_to(%0d,%0d): not reached, got %0d steps want < 4000", r, c, n);
        end
    endtask

    initial begin
        logic [27:0] act;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        act = {row, col, R_out, G_out, B_out, pixel_valid, frame_start, locked, h_err, v_err};
        checks++;
        if (act === 28'd0) passes++;
        else $display("FAIL reset_state: got %h want 0000000", act);
        reset = 1'b1;
        repeat (10) idle_px();

        // Golden stream from (0,5): HTRACK at (0,18), LOCKED at (10,0).
        srow = 0;
        scol = 5;
        run_to(0, 0);
        run_to(0, 0);
        // Frame 3: pixel-valid count checked at (0,0); HSync falls 10 pixels early.
        run_to(3, HS_COL - 10);
        scol = HS_COL;
        drive_px(1'b1, 1'b0, 1'b0);
        run_to(2, 0);
        // Frame 4: HSync pulse of row 2 suppressed.
        sup_row = 2;
        run_to(4, 0);
        sup_row = -1;
        run_to(VS_ROW - 1, 0);
        run_to(VS_ROW - 1, 0);
        // Frame 5: VSync falls one line early.
        srow = VS_ROW;
        drive_px(1'b0, 1'b1, 1'b0);
        run_to(0, 0);
        run_to(0, 0);
        // Frame 7: reset pulse at (4,5), then full relock.
        run_to(4, 5);
        drive_px(1'b0, 1'b0, 1'b1);
        run_to(0, 0);
        run_to(0, 6);

        repeat (4) @(posedge clk);
        #3;
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending want 0", q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
